conv_mac: RTL and testbench

CONV_MAC -- requirements
Module: conv_mac

---
 rtl/cnn_pkg.sv | 10 +
 rtl/conv_mac_if.sv | 15 +
 rtl/tap_sel.sv | 12 +
 rtl/conv_mac.sv | 129 ++++++++++++
 tb/tb_conv_mac.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/cnn_pkg.sv
// Shared widths and FSM encoding for the 5x5 convolution MAC.
package cnn_pkg;
  localparam int KTAPS = 25;
  localparam int DW    = 32;
  localparam int PW    = 64;
  localparam int AW    = 69;
  localparam int IW    = 5;

  typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;
endpackage

// File: rtl/conv_mac_if.sv
// Pixel stream in / result stream out of conv_mac.
interface conv_mac_if;
  import cnn_pkg::*;

  logic                 iValid;
  logic signed [DW-1:0] iPix;
  logic                 iClear;
  logic                 oValid;
  logic [DW-1:0]        oY;
  logic                 oOvf;
  logic [IW-1:0]        oIdx;

  modport master (output iValid, iPix, iClear, input oValid, oY, oOvf, oIdx);
  modport slave  (input iValid, iPix, iClear, output oValid, oY, oOvf, oIdx);
endinterface

// File: rtl/tap_sel.sv
// 25:1 weight selector driven by the current tap index.
module tap_sel import cnn_pkg::*; (
  input  logic [KTAPS-1:0][DW-1:0] i_taps,
  input  logic [IW-1:0]            i_idx,
  output logic [DW-1:0]            o_tap
);
  always_comb begin
    o_tap = '0;
    for (int k = 0; k < KTAPS; k++)
      if (i_idx == IW'(k)) o_tap = i_taps[k];
  end
endmodule

// File: rtl/conv_mac.sv
// 25-tap convolution MAC: multiply, accumulate, then bias/shift/saturate/ReLU.
// Three-stage pipeline, one pixel per cycle, result strobe 3 cycles after tap 24.
module conv_mac import cnn_pkg::*; #(
  parameter int SHIFT = 16
) (
  input logic                 clk,
  input logic                 rst,
  conv_mac_if.slave           s,
  input logic signed [DW-1:0] w1,  w2,  w3,  w4,  w5,
  input logic signed [DW-1:0] w6,  w7,  w8,  w9,  w10,
  input logic signed [DW-1:0] w11, w12, w13, w14, w15,
  input logic signed [DW-1:0] w16, w17, w18, w19, w20,
  input logic signed [DW-1:0] w21, w22, w23, w24, w25,
  input logic signed [DW-1:0] iBias,
  input logic                 iRelu
);
  localparam logic signed [AW-1:0] YMAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] YMIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  state_t                   r_state, w_state_nxt;
  logic [IW-1:0]            r_idx, w_idx_nxt;
  logic [2:0]               r_vld_pipe;
  logic signed [PW-1:0]     r_prod;
  logic                     r_first, r_last1, r_last2;
  logic signed [AW-1:0]     r_acc;
  logic [DW-1:0]            r_y;
  logic                     r_ovf;

  logic                     w_accept, w_last_tap, w_fire;
  logic [KTAPS-1:0][DW-1:0] w_taps;
  logic [DW-1:0]            w_tap;
  logic signed [PW-1:0]     w_pix_x, w_tap_x, w_prod;
  logic signed [AW-1:0]     w_prod_x, w_sum, w_shr;
  logic [DW-1:0]            w_sat, w_y;
  logic                     w_ovf;

  assign w_accept   = s.iValid & ~s.iClear;
  assign w_last_tap = (r_idx == IW'(KTAPS-1));
  assign w_taps = {w25, w24, w23, w22, w21, w20, w19, w18, w17, w16, w15, w14, w13,
                   w12, w11, w10, w9, w8, w7, w6, w5, w4, w3, w2, w1};

  tap_sel u_tap_sel (.i_taps(w_taps), .i_idx(r_idx), .o_tap(w_tap));

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      IDLE: if (w_accept) begin
        w_state_nxt = ACC;
        w_idx_nxt   = IW'(1);
      end
      ACC: if (s.iClear) begin
        w_state_nxt = IDLE;
        w_idx_nxt   = '0;
      end else if (s.iValid) begin
        w_state_nxt = w_last_tap ? IDLE : ACC;
        w_idx_nxt   = w_last_tap ? '0 : r_idx + IW'(1);
      end
      default: begin
        w_state_nxt = IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  assign w_pix_x  = {{(PW-DW){s.iPix[DW-1]}}, s.iPix};
  assign w_tap_x  = {{(PW-DW){w_tap[DW-1]}}, w_tap};
  assign w_prod   = w_pix_x * w_tap_x;
  assign w_prod_x = {{(AW-PW){r_prod[PW-1]}}, r_prod};

  // Bias and ReLU are sampled here, in the same cycle the window completes.
  assign w_sum = r_acc + {{(AW-DW){iBias[DW-1]}}, iBias};
  assign w_shr = w_sum >>> SHIFT;

  always_comb begin
    w_ovf = 1'b0;
    w_sat = w_shr[DW-1:0];
    if (w_shr > YMAX) begin
      w_sat = {1'b0, {(DW-1){1'b1}}};
      w_ovf = 1'b1;
    end else if (w_shr < YMIN) begin
      w_sat = {1'b1, {(DW-1){1'b0}}};
      w_ovf = 1'b1;
    end
    w_y = (iRelu && w_sat[DW-1]) ? '0 : w_sat;
  end

  // A clear kills anything still in stage 1/2 so the aborted window never strobes.
  assign w_fire = r_vld_pipe[1] & r_last2 & ~s.iClear;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_vld_pipe <= '0;
      r_prod     <= '0;
      r_first    <= 1'b0;
      r_last1    <= 1'b0;
      r_last2    <= 1'b0;
      r_acc      <= '0;
      r_y        <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_idx         <= w_idx_nxt;
      r_vld_pipe[0] <= w_accept;
      r_vld_pipe[1] <= r_vld_pipe[0] & ~s.iClear;
      r_vld_pipe[2] <= w_fire;
      if (w_accept) begin
        r_prod  <= w_prod;
        r_first <= (r_idx == '0);
        r_last1 <= w_last_tap;
      end
      if (r_vld_pipe[0]) begin
        r_acc   <= r_first ? w_prod_x : r_acc + w_prod_x;
        r_last2 <= r_last1;
      end
      if (w_fire) begin
        r_y   <= w_y;
        r_ovf <= w_ovf;
      end
    end
  end

  assign s.oValid = r_vld_pipe[2];
  assign s.oY     = r_y;
  assign s.oOvf   = r_ovf;
  assign s.oIdx   = r_idx;
endmodule

// File: tb/tb_conv_mac.sv
// Bench for conv_mac: SHIFT=0 and SHIFT=16 instances share one stimulus stream,
// checked against a wide-integer window model and a timed expectation queue.
module tb_conv_mac;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic signed [31:0] w [25];
  logic signed [31:0] bias = '0;
  logic relu = 1'b0;
  int cyc = 0;
  int n_chk = 0, n_err = 0, n_res = 0;
  bit mon_en = 1'b0;

  conv_mac_if a ();
  conv_mac_if b ();
  assign b.iValid = a.iValid;
  assign b.iPix   = a.iPix;
  assign b.iClear = a.iClear;

  conv_mac #(.SHIFT(0)) dut0 (
    .clk(clk), .rst(rst), .s(a),
    .w1(w[0]), .w2(w[1]), .w3(w[2]), .w4(w[3]), .w5(w[4]),
    .w6(w[5]), .w7(w[6]), .w8(w[7]), .w9(w[8]), .w10(w[9]),
    .w11(w[10]), .w12(w[11]), .w13(w[12]), .w14(w[13]), .w15(w[14]),
    .w16(w[15]), .w17(w[16]), .w18(w[17]), .w19(w[18]), .w20(w[19]),
    .w21(w[20]), .w22(w[21]), .w23(w[22]), .w24(w[23]), .w25(w[24]),
    .iBias(bias), .iRelu(relu));

  conv_mac #(.SHIFT(16)) dut16 (
    .clk(clk), .rst(rst), .s(b),
    .w1(w[0]), .w2(w[1]), .w3(w[2]), .w4(w[3]), .w5(w[4]),
    .w6(w[5]), .w7(w[6]), .w8(w[7]), .w9(w[8]), .w10(w[9]),
    .w11(w[10]), .w12(w[11]), .w13(w[12]), .w14(w[13]), .w15(w[14]),
    .w16(w[15]), .w17(w[16]), .w18(w[17]), .w19(w[18]), .w20(w[19]),
    .w21(w[20]), .w22(w[21]), .w23(w[22]), .w24(w[23]), .w25(w[24]),
    .iBias(bias), .iRelu(relu));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] y0;
    bit          o0;
    logic [31:0] y16;
    bit          o16;
    int          cyc;
  } exp_t;
  exp_t q[$];

  localparam logic signed [127:0] MAXV = 128'sd2147483647;
  localparam logic signed [127:0] MINV = -128'sd2147483648;

  logic signed [127:0] m_acc = '0;
  int m_idx = 0;
  logic [31:0] last_y0 = '0, last_y16 = '0, prev_y0 = '0;
  bit last_o0 = 1'b0, last_o16 = 1'b0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic void ref_out(input logic signed [127:0] acc, input int sh,
                                  output logic [31:0] y, output bit ovf);
    logic signed [127:0] v;
    v   = (acc + bias) >>> sh;
    ovf = 1'b0;
    if (v > MAXV) begin y = 32'h7FFF_FFFF; ovf = 1'b1; end
    else if (v < MINV) begin y = 32'h8000_0000; ovf = 1'b1; end
    else y = v[31:0];
    if (relu && y[31]) y = '0;
  endfunction

  // Drive one cycle of inputs, update the window model, then step to the next cycle.
  task automatic px(input logic signed [31:0] pix, input bit vld, input bit clr = 1'b0,
                    input bit rn = 1'b1);
    exp_t e;
    chk("oIdx", a.oIdx, m_idx);
    rst = rn; a.iValid = vld; a.iPix = pix; a.iClear = clr;
    if (!rn || clr) begin
      m_idx = 0; m_acc = '0;
    end else if (vld) begin
      if (m_idx == 0) m_acc = '0;
      m_acc += pix * w[m_idx];
      if (m_idx == 24) begin
        ref_out(m_acc, 0, e.y0, e.o0);
        ref_out(m_acc, 16, e.y16, e.o16);
        e.cyc = cyc + 3;
        q.push_back(e);
        m_idx = 0;
      end else m_idx++;
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rnd();
    case ($urandom_range(0, 2))
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 400)) - 32'd200;
      default: return ($urandom_range(0, 1) != 0) ? ($urandom & 32'h0003_FFFF)
                                                   : -($urandom & 32'h0003_FFFF);
    endcase
  endfunction

  always @(negedge clk) if (mon_en) begin
    exp_t e;
    chk("vld16", b.oValid, a.oValid);
    if (q.size() > 0 && q[0].cyc < cyc) begin
      chk("missing_strobe", 0, 1);
      void'(q.pop_front());
    end
    if (rst === 1'b0) begin
      last_y0 = '0; last_y16 = '0; last_o0 = 1'b0; last_o16 = 1'b0;
    end else if (a.oValid === 1'b1) begin
      if (q.size() == 0) chk("spurious_strobe", 1, 0);
      else begin
        e = q.pop_front();
        chk("latency", cyc, e.cyc);
        chk("y0", a.oY, e.y0);
        chk("ovf0", a.oOvf, e.o0);
        chk("y16", b.oY, e.y16);
        chk("ovf16", b.oOvf, e.o16);
        n_res++;
      end
      prev_y0 = last_y0;
      last_y0 = a.oY; last_o0 = a.oOvf; last_y16 = b.oY; last_o16 = b.oOvf;
    end else begin
      chk("hold_y0", a.oY, last_y0);
      chk("hold_ovf0", a.oOvf, last_o0);
      chk("hold_y16", b.oY, last_y16);
    end
  end

  initial begin
    int base;
    int abort;
    bit done;
    for (int k = 0; k < 25; k++) w[k] = '0;
    a.iValid = 1'b0; a.iPix = '0; a.iClear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld", a.oValid, 0);
    chk("rst_y", a.oY, 0);
    chk("rst_ovf", a.oOvf, 0);
    chk("rst_idx", a.oIdx, 0);
    chk("rst_y16", b.oY, 0);
    mon_en = 1'b1;

    // ramp 1..25 with unit weights
    for (int k = 0; k < 25; k++) w[k] = 32'sd1;
    for (int k = 1; k <= 25; k++) px(k, 1);
    repeat (5) px(0, 0);
    chk("ramp_y0", last_y0, 325);
    chk("ramp_ovf0", last_o0, 0);

    // single centre tap in Q16.16
    for (int k = 0; k < 25; k++) w[k] = '0;
    w[12] = 32'sh0001_0000;
    for (int k = 0; k < 25; k++) px((k == 12) ? 32'sh0003_0000 : 32'sh7FFF_0000, 1);
    repeat (5) px(0, 0);
    chk("q16_y16", last_y16, 32'h0003_0000);
    chk("q16_ovf16", last_o16, 0);

    // positive and negative saturation
    for (int k = 0; k < 25; k++) w[k] = 32'sh7FFF_FFFF;
    repeat (25) px(32'sh7FFF_FFFF, 1);
    repeat (5) px(0, 0);
    chk("satp_y0", last_y0, 32'h7FFF_FFFF);
    chk("satp_ovf0", last_o0, 1);
    repeat (25) px(-32'sh7FFF_FFFF, 1);
    repeat (5) px(0, 0);
    chk("satn_y0", last_y0, 32'h8000_0000);
    chk("satn_ovf0", last_o0, 1);

    // ReLU off / on
    for (int k = 0; k < 25; k++) w[k] = 32'sd1;
    repeat (25) px(-32'sd1, 1);
    repeat (5) px(0, 0);
    chk("relu0_y0", last_y0, 32'hFFFF_FFE7);
    relu = 1'b1;
    repeat (25) px(-32'sd1, 1);
    repeat (5) px(0, 0);
    chk("relu1_y0", last_y0, 0);
    chk("relu1_ovf0", last_o0, 0);
    relu = 1'b0;

    // abort after 10 taps with a clear that also carries a pixel
    base = n_res;
    for (int k = 0; k < 10; k++) px(32'sd9, 1);
    px(32'sd9, 1, 1);
    repeat (25) px(32'sd2, 1);
    repeat (5) px(0, 0);
    chk("clr_count", n_res - base, 1);
    chk("clr_y0", last_y0, 50);

    // back-to-back windows, then reset in the middle of a third
    base = n_res;
    repeat (25) px(32'sd1, 1);
    repeat (25) px(32'sd3, 1);
    repeat (12) px(32'sd7, 1);
    chk("b2b_first", prev_y0, 25);
    chk("b2b_second", last_y0, 75);
    px(32'sd7, 1, 0, 0);
    repeat (10) px(0, 0);
    chk("b2b_count", n_res - base, 2);

    // randomized windows: gaps, mid-window weight changes, occasional aborts
    for (int n = 0; n < 24; n++) begin
      repeat (4) px(0, 0);
      bias = rnd();
      relu = ($urandom_range(0, 1) != 0);
      for (int k = 0; k < 25; k++) w[k] = rnd();
      abort = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 24) : 99;
      done = 1'b0;
      for (int k = 0; k < 25 && !done; k++) begin
        while ($urandom_range(0, 3) == 0) px(rnd(), 0);
        if ($urandom_range(0, 7) == 0) w[$urandom_range(0, 24)] = rnd();
        if (k == abort) begin
          px(rnd(), 1, 1);
          done = 1'b1;
        end else px(rnd(), 1);
      end
    end
    repeat (6) px(0, 0);
    chk("queue_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
